// File: rtl/tb_end_checker_if.sv
// ---------------------------------------------------------------------------
// tb_end_checker_if
//   Bundles the signals between a simulation top and tb_end_checker.
//
//   The "master" modport is the side that feeds the checker:
//     wb_valid, wb_pc, chk_data  out
//     done, pass, fail, timeout  in
//     fail_idx, fail_val         in
//     cyc_cnt                    in
//   The "slave" modport is the checker itself, with the same signals in the
//   opposite directions.
//
//   fail_idx is clog2(NUM_CHECKS) bits wide. It is held at a minimum of one
//   bit so that a single-check configuration still has a legal port.
// ---------------------------------------------------------------------------
interface tb_end_checker_if #(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CHECKS = 2
);
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic                         wb_valid;
  logic [PC_W-1:0]              wb_pc;
  logic [NUM_CHECKS*DATA_W-1:0] chk_data;

  logic                         done;
  logic                         pass;
  logic                         fail;
  logic                         timeout;
  logic [IDX_W-1:0]             fail_idx;
  logic [DATA_W-1:0]            fail_val;
  logic [31:0]                  cyc_cnt;

  modport master (
    output wb_valid, wb_pc, chk_data,
    input  done, pass, fail, timeout, fail_idx, fail_val, cyc_cnt
  );

  modport slave (
    input  wb_valid, wb_pc, chk_data,
    output done, pass, fail, timeout, fail_idx, fail_val, cyc_cnt
  );
endinterface

// File: rtl/tb_end_checker.sv
// ---------------------------------------------------------------------------
// tb_end_checker
//   End-of-test checker for a simulation top.
//
//   The checker watches retired PCs at writeback and waits for END_PC to
//   retire. After SETTLE further cycles it compares NUM_CHECKS live values
//   against EXP_VALS, one slot per cycle, and then settles into PASS or FAIL.
//   If END_PC does not retire within TIMEOUT cycles, the test fails with
//   timeout set. A TIMEOUT of 0 disables the timeout.
//
//   Ports
//     clk    in  clock
//     reset  in  synchronous, active-high reset
//     bus    tb_end_checker_if.slave:
//              wb_valid, wb_pc  retirement stream
//              chk_data         live values under test
//                               (slot i at [i*DATA_W +: DATA_W])
//              done, pass, fail, timeout
//                               sticky status
//              fail_idx, fail_val
//                               first mismatching slot and its value
//              cyc_cnt          cycles spent in RUN (saturating)
//
//   Optional feature macro: TB_END_CHECKER_FINISH_EN
//     When defined, the checker prints a PASS/FAIL banner on entry to a
//     terminal state. It then ends the simulation one cycle after done rises.
//     When undefined, the result is visible on the ports only.
// ---------------------------------------------------------------------------
module tb_end_checker #(
  parameter int                         PC_W       = 32,
  parameter int                         DATA_W     = 32,
  parameter int                         NUM_CHECKS = 2,
  parameter logic [PC_W-1:0]            END_PC     = 32'h1c000018,
  parameter logic [NUM_CHECKS*DATA_W-1:0] EXP_VALS = {32'h56, 32'h5a},
  parameter int unsigned                TIMEOUT    = 20000,
  parameter int unsigned                SETTLE     = 1
) (
  input  logic            clk,
  input  logic            reset,
  tb_end_checker_if.slave bus
);

  localparam int               IDX_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHECKS - 1);
  localparam logic             TMO_EN      = (TIMEOUT != 0);
  localparam logic [31:0]      TMO_LAST    = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic             SETTLE_EN   = (SETTLE != 0);
  localparam logic [31:0]      SETTLE_LOAD = (SETTLE == 0) ? 32'd0 : 32'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_e;

  state_e            state_q,    state_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [31:0]       settle_q,   settle_d;
  logic [31:0]       cyc_cnt_q,  cyc_cnt_d;
  logic              timeout_q,  timeout_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0] fail_val_q, fail_val_d;
  logic              done_q,     done_d;
  logic              pass_q,     pass_d;
  logic              fail_q,     fail_d;

  logic              end_hit;
  logic [DATA_W-1:0] cur_slot;
  logic [DATA_W-1:0] exp_slot;

  // The PC is compared with case equality, so an X/Z on wb_pc never counts
  // as a hit.
  assign end_hit = bus.wb_valid && (bus.wb_pc === END_PC);

  // Select the live slot and its expected constant for the current index.
  // chk_data is deliberately not snapshotted.
  always_comb begin
    cur_slot = '0;
    exp_slot = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_slot = bus.chk_data[i*DATA_W +: DATA_W];
        exp_slot = EXP_VALS[i*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      idx_q      <= '0;
      settle_q   <= '0;
      cyc_cnt_q  <= '0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
      fail_val_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      cyc_cnt_q  <= cyc_cnt_d;
      timeout_q  <= timeout_d;
      fail_idx_q <= fail_idx_d;
      fail_val_q <= fail_val_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  // Next-state logic.
  // In RUN, an END_PC hit takes priority over a timeout that expires in the
  // same cycle. PASS and FAIL hold until reset.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    cyc_cnt_d  = cyc_cnt_q;
    timeout_d  = timeout_q;
    fail_idx_d = fail_idx_q;
    fail_val_d = fail_val_q;
    unique case (state_q)
      S_RUN: begin
        if (cyc_cnt_q != 32'hffffffff) begin
          cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
        if (end_hit) begin
          idx_d = '0;
          if (SETTLE_EN) begin
            state_d  = S_SETTLE;
            settle_d = SETTLE_LOAD;
          end else begin
            state_d = S_CHECK;
          end
        end else if (TMO_EN && (cyc_cnt_q == TMO_LAST)) begin
          state_d   = S_FAIL;
          timeout_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == 32'd0) begin
          state_d = S_CHECK;
          idx_d   = '0;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      S_CHECK: begin
        if (cur_slot !== exp_slot) begin
          state_d    = S_FAIL;
          fail_idx_d = idx_q;
          fail_val_d = cur_slot;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_PASS;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output logic.
  // Status flags are decoded from the next state so that they are registered
  // and rise on the same edge that enters PASS or FAIL.
  always_comb begin
    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = (state_d == S_PASS);
    fail_d = (state_d == S_FAIL);
  end

  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.timeout  = timeout_q;
  assign bus.fail_idx = fail_idx_q;
  assign bus.fail_val = fail_val_q;
  assign bus.cyc_cnt  = cyc_cnt_q;

`ifdef TB_END_CHECKER_FINISH_EN
  logic done_seen_q;

  // Print the banner on the edge that enters a terminal state, then end the
  // simulation on the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_seen_q <= 1'b0;
    end else begin
      done_seen_q <= done_q;
      if (done_d && !done_q) begin
        if (pass_d) begin
          $display("tb_end_checker: PASS (cyc_cnt=%0d)", cyc_cnt_d);
        end else if (timeout_d) begin
          $display("tb_end_checker: FAIL TIMEOUT cyc_cnt=%0d", cyc_cnt_d);
        end else begin
          $display("tb_end_checker: FAIL idx=%0d expected=%h got=%h",
                   fail_idx_d, exp_slot, fail_val_d);
        end
      end
      if (done_q && !done_seen_q) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tb_end_checker.sv
// ---------------------------------------------------------------------------
// tb_tb_end_checker
//   Self-checking bench for tb_end_checker. Three instances are used:
//     A: NUM_CHECKS=2, SETTLE=1, TIMEOUT=20000 (default expected values)
//     B: NUM_CHECKS=2, SETTLE=3, TIMEOUT=100
//     C: NUM_CHECKS=4, SETTLE=0, TIMEOUT=0 (timeout disabled)
//   All instances share the retirement stream and reset. "sel" picks which
//   instance's outputs are observed. Expected outcomes come from a model
//   that is applied per test.
// ---------------------------------------------------------------------------
module tb_tb_end_checker;

  localparam logic [31:0] END_PC = 32'h1c000018;
  localparam logic [31:0] C_EXP0 = 32'h13579bdf;
  localparam logic [31:0] C_EXP1 = 32'hcafef00d;
  localparam logic [31:0] C_EXP2 = 32'h01234567;
  localparam logic [31:0] C_EXP3 = 32'hdeadbeef;

  logic         clk      = 1'b0;
  logic         reset    = 1'b0;
  logic         wb_valid = 1'b0;
  logic [31:0]  wb_pc    = '0;
  logic [127:0] drv_data = '0;
  int           sel      = 0;
  int           n_checks = 0;
  int           n_pass   = 0;

  int          settle_p [3] = '{1, 3, 0};
  int          nchk_p   [3] = '{2, 2, 4};
  int          tmo_p    [3] = '{20000, 100, 0};
  logic [31:0] exp_p [3][4] = '{'{32'h5a, 32'h56, 32'h0, 32'h0},
                                '{32'h5a, 32'h56, 32'h0, 32'h0},
                                '{C_EXP0, C_EXP1, C_EXP2, C_EXP3}};

  always #5 clk = ~clk;

  tb_end_checker_if #(.PC_W(32), .DATA_W(32), .NUM_CHECKS(2)) if_a ();
  tb_end_checker_if #(.PC_W(32), .DATA_W(32), .NUM_CHECKS(2)) if_b ();
  tb_end_checker_if #(.PC_W(32), .DATA_W(32), .NUM_CHECKS(4)) if_c ();

  assign if_a.wb_valid = wb_valid;
  assign if_a.wb_pc    = wb_pc;
  assign if_a.chk_data = drv_data[63:0];
  assign if_b.wb_valid = wb_valid;
  assign if_b.wb_pc    = wb_pc;
  assign if_b.chk_data = drv_data[63:0];
  assign if_c.wb_valid = wb_valid;
  assign if_c.wb_pc    = wb_pc;
  assign if_c.chk_data = drv_data;

  tb_end_checker #(.NUM_CHECKS(2), .TIMEOUT(20000), .SETTLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave)
  );
  tb_end_checker #(.NUM_CHECKS(2), .TIMEOUT(100), .SETTLE(3)) u_dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave)
  );
  tb_end_checker #(.NUM_CHECKS(4), .EXP_VALS({C_EXP3, C_EXP2, C_EXP1, C_EXP0}),
                   .TIMEOUT(0), .SETTLE(0)) u_dut_c (
    .clk(clk), .reset(reset), .bus(if_c.slave)
  );

  logic        obs_done, obs_pass, obs_fail, obs_timeout;
  logic [1:0]  obs_idx;
  logic [31:0] obs_val, obs_cyc;

  always_comb begin
    obs_done    = if_a.done;
    obs_pass    = if_a.pass;
    obs_fail    = if_a.fail;
    obs_timeout = if_a.timeout;
    obs_idx     = {1'b0, if_a.fail_idx};
    obs_val     = if_a.fail_val;
    obs_cyc     = if_a.cyc_cnt;
    if (sel == 1) begin
      obs_done    = if_b.done;
      obs_pass    = if_b.pass;
      obs_fail    = if_b.fail;
      obs_timeout = if_b.timeout;
      obs_idx     = {1'b0, if_b.fail_idx};
      obs_val     = if_b.fail_val;
      obs_cyc     = if_b.cyc_cnt;
    end else if (sel == 2) begin
      obs_done    = if_c.done;
      obs_pass    = if_c.pass;
      obs_fail    = if_c.fail;
      obs_timeout = if_c.timeout;
      obs_idx     = if_c.fail_idx;
      obs_val     = if_c.fail_val;
      obs_cyc     = if_c.cyc_cnt;
    end
  end

  // Drive one cycle of inputs and return at the following falling edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [127:0] d);
    wb_valid = v;
    wb_pc    = pc;
    drv_data = d;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if (r == END_PC) r = r ^ 32'h4;
    return r;
  endfunction

  function automatic logic [127:0] exp_data(input int s);
    logic [127:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = exp_p[s][i];
    return d;
  endfunction

  // Reset is held for one edge while an END_PC retirement is presented.
  task automatic do_reset(input logic [127:0] d);
    reset = 1'b1;
    step(1'b1, END_PC, d);
    reset = 1'b0;
  endtask

  task automatic test_reset(input string name);
    do_reset({$urandom, $urandom, $urandom, $urandom});
    n_checks++; if (obs_done !== 1'b0) $display("[TB] FAIL %s done: got %b want 0", name, obs_done); else n_pass++;
    n_checks++; if (obs_pass !== 1'b0) $display("[TB] FAIL %s pass: got %b want 0", name, obs_pass); else n_pass++;
    n_checks++; if (obs_fail !== 1'b0) $display("[TB] FAIL %s fail: got %b want 0", name, obs_fail); else n_pass++;
    n_checks++; if (obs_timeout !== 1'b0) $display("[TB] FAIL %s timeout: got %b want 0", name, obs_timeout); else n_pass++;
    n_checks++; if (obs_idx !== 2'd0) $display("[TB] FAIL %s fail_idx: got %0d want 0", name, obs_idx); else n_pass++;
    n_checks++; if (obs_val !== 32'd0) $display("[TB] FAIL %s fail_val: got %h want 0", name, obs_val); else n_pass++;
    n_checks++; if (obs_cyc !== 32'd0) $display("[TB] FAIL %s cyc_cnt: got %0d want 0", name, obs_cyc); else n_pass++;
    step(1'b0, rand_pc(), drv_data);
    n_checks++; if (obs_cyc !== 32'd1) $display("[TB] FAIL %s run_count: got %0d want 1", name, obs_cyc); else n_pass++;
  endtask

  // One complete end-of-test scenario on instance s.
  //   n_pre retirements happen before END_PC.
  //   After the hit edge, the cycle k (1-based) drives d_hit when k < sw and
  //   d_chk otherwise.
  // The model says slot i is compared on post-hit edge SETTLE+1+i, and done
  // follows SETTLE + (number of slots compared) edges after the hit.
  task automatic run_case(input int s, input bit seq, input int n_pre,
                          input logic [127:0] d_hit, input logic [127:0] d_chk,
                          input int sw, input string name);
    bit          exp_fail;
    int          exp_idx, n_cmp, lat, got, k, vr;
    logic [31:0] exp_val, v;
    exp_fail = 1'b0;
    exp_idx  = 0;
    exp_val  = '0;
    n_cmp    = nchk_p[s];
    for (int i = 0; i < nchk_p[s]; i++) begin
      k = settle_p[s] + 1 + i;
      v = (k < sw) ? d_hit[i*32 +: 32] : d_chk[i*32 +: 32];
      if (!exp_fail && (v !== exp_p[s][i])) begin
        exp_fail = 1'b1;
        exp_idx  = i;
        exp_val  = v;
        n_cmp    = i + 1;
      end
    end
    lat = settle_p[s] + n_cmp;

    sel = s;
    do_reset(d_hit);
    for (int c = 0; c < n_pre; c++) begin
      if (seq) begin
        step(1'b1, END_PC - 32'(4 * (n_pre - c)), d_hit);
      end else begin
        vr = $urandom_range(0, 1);
        step(1'(vr), (vr == 0 && $urandom_range(0, 3) == 0) ? END_PC : rand_pc(), d_hit);
      end
    end
    step(1'b1, END_PC, d_hit);
    got = (obs_done === 1'b1) ? 0 : -1;
    for (int kk = 1; kk <= lat + 4 && got < 0; kk++) begin
      step(1'($urandom_range(0, 1)), $urandom, (kk < sw) ? d_hit : d_chk);
      if (obs_done === 1'b1) got = kk;
    end

    n_checks++; if (got != lat) $display("[TB] FAIL %s latency: got %0d want %0d", name, got, lat); else n_pass++;
    n_checks++; if (obs_pass !== !exp_fail) $display("[TB] FAIL %s pass: got %b want %b", name, obs_pass, !exp_fail); else n_pass++;
    n_checks++; if (obs_fail !== exp_fail) $display("[TB] FAIL %s fail: got %b want %b", name, obs_fail, exp_fail); else n_pass++;
    n_checks++; if (obs_timeout !== 1'b0) $display("[TB] FAIL %s timeout: got %b want 0", name, obs_timeout); else n_pass++;
    n_checks++; if (obs_cyc !== 32'(n_pre + 1)) $display("[TB] FAIL %s cyc_cnt: got %0d want %0d", name, obs_cyc, n_pre + 1); else n_pass++;
    if (exp_fail) begin
      n_checks++; if (obs_idx !== 2'(exp_idx)) $display("[TB] FAIL %s fail_idx: got %0d want %0d", name, obs_idx, exp_idx); else n_pass++;
      n_checks++; if (obs_val !== exp_val) $display("[TB] FAIL %s fail_val: got %h want %h", name, obs_val, exp_val); else n_pass++;
    end
    for (int j = 0; j < 3; j++) step(1'b1, END_PC, ~d_chk);
    n_checks++;
    if (obs_done !== 1'b1 || obs_pass !== !exp_fail || obs_fail !== exp_fail)
      $display("[TB] FAIL %s sticky: got done=%b pass=%b fail=%b want done=1 pass=%b fail=%b",
               name, obs_done, obs_pass, obs_fail, !exp_fail, exp_fail);
    else n_pass++;
  endtask

  task automatic test_pass_sequence();
    run_case(0, 1'b1, 6, exp_data(0), exp_data(0), 0, "end_pc_pass");
  endtask

  task automatic test_mismatch();
    run_case(0, 1'b0, 5, {64'h0, 32'h57, 32'h5a}, {64'h0, 32'h57, 32'h5a}, 0, "slot1_mismatch");
  endtask

  task automatic test_x_slot();
    logic [127:0] d;
    d = {64'h0, 32'h56, 32'hxxxxxxxx};
    run_case(0, 1'b0, 3, d, d, 0, "slot0_x");
  endtask

  task automatic test_live_data();
    run_case(0, 1'b0, 4, {64'h0, 32'h56, 32'h0}, exp_data(0), 2, "live_fix_slot0");
    run_case(0, 1'b0, 4, exp_data(0), {64'h0, 32'h0, 32'h5a}, 3, "live_break_slot1");
  endtask

  task automatic test_timeout();
    int got, vr;
    sel = 1;
    do_reset(exp_data(1));
    got = -1;
    for (int c = 1; c <= tmo_p[1] + 20 && got < 0; c++) begin
      vr = $urandom_range(0, 1);
      step(1'(vr), (vr != 0) ? rand_pc() : END_PC, exp_data(1));
      if (obs_done === 1'b1) got = c;
    end
    n_checks++; if (got != tmo_p[1]) $display("[TB] FAIL timeout latency: got %0d want %0d", got, tmo_p[1]); else n_pass++;
    n_checks++; if (obs_timeout !== 1'b1) $display("[TB] FAIL timeout flag: got %b want 1", obs_timeout); else n_pass++;
    n_checks++; if (obs_fail !== 1'b1) $display("[TB] FAIL timeout fail: got %b want 1", obs_fail); else n_pass++;
    n_checks++; if (obs_pass !== 1'b0) $display("[TB] FAIL timeout pass: got %b want 0", obs_pass); else n_pass++;
    n_checks++; if (obs_cyc !== 32'(tmo_p[1])) $display("[TB] FAIL timeout cyc_cnt: got %0d want %0d", obs_cyc, tmo_p[1]); else n_pass++;
    for (int j = 0; j < 4; j++) step(1'b1, END_PC, exp_data(1));
    n_checks++;
    if (obs_timeout !== 1'b1 || obs_fail !== 1'b1 || obs_pass !== 1'b0 || obs_cyc !== 32'(tmo_p[1]))
      $display("[TB] FAIL timeout sticky: got timeout=%b fail=%b pass=%b cyc=%0d want 1 1 0 %0d",
               obs_timeout, obs_fail, obs_pass, obs_cyc, tmo_p[1]);
    else n_pass++;
  endtask

  task automatic test_hit_vs_timeout();
    int got;
    sel = 1;
    do_reset(exp_data(1));
    for (int c = 0; c < tmo_p[1] - 1; c++) step(1'b0, END_PC, exp_data(1));
    n_checks++; if (obs_cyc !== 32'(tmo_p[1] - 1) || obs_done !== 1'b0)
      $display("[TB] FAIL race pre: got cyc=%0d done=%b want cyc=%0d done=0", obs_cyc, obs_done, tmo_p[1] - 1); else n_pass++;
    step(1'b1, END_PC, exp_data(1));
    n_checks++; if (obs_timeout !== 1'b0) $display("[TB] FAIL race timeout: got %b want 0", obs_timeout); else n_pass++;
    n_checks++; if (obs_done !== 1'b0) $display("[TB] FAIL race done: got %b want 0", obs_done); else n_pass++;
    n_checks++; if (obs_cyc !== 32'(tmo_p[1])) $display("[TB] FAIL race cyc_cnt: got %0d want %0d", obs_cyc, tmo_p[1]); else n_pass++;
    got = -1;
    for (int kk = 1; kk <= settle_p[1] + 6 && got < 0; kk++) begin
      step(1'b0, rand_pc(), exp_data(1));
      if (obs_done === 1'b1) got = kk;
    end
    n_checks++; if (got != settle_p[1] + 2) $display("[TB] FAIL race latency: got %0d want %0d", got, settle_p[1] + 2); else n_pass++;
    n_checks++; if (obs_pass !== 1'b1 || obs_timeout !== 1'b0)
      $display("[TB] FAIL race result: got pass=%b timeout=%b want pass=1 timeout=0", obs_pass, obs_timeout); else n_pass++;
  endtask

  task automatic test_reset_mid_check();
    logic [127:0] d;
    sel = 2;
    d = exp_data(2);
    do_reset(d);
    for (int c = 0; c < 300; c++) step(1'($urandom_range(0, 1)), rand_pc(), d);
    n_checks++; if (obs_done !== 1'b0 || obs_cyc !== 32'd300)
      $display("[TB] FAIL no_timeout: got done=%b cyc=%0d want done=0 cyc=300", obs_done, obs_cyc); else n_pass++;
    step(1'b1, END_PC, d);
    step(1'b0, rand_pc(), d);
    step(1'b0, rand_pc(), d);
    reset = 1'b1;
    step(1'b0, rand_pc(), d);
    reset = 1'b0;
    n_checks++; if (obs_done !== 1'b0 || obs_pass !== 1'b0 || obs_fail !== 1'b0)
      $display("[TB] FAIL midreset flags: got done=%b pass=%b fail=%b want 0 0 0", obs_done, obs_pass, obs_fail); else n_pass++;
    n_checks++; if (obs_cyc !== 32'd0) $display("[TB] FAIL midreset cyc_cnt: got %0d want 0", obs_cyc); else n_pass++;
    for (int c = 0; c < 6; c++) step(1'($urandom_range(0, 1)), rand_pc(), d);
    n_checks++; if (obs_done !== 1'b0 || obs_cyc !== 32'd6)
      $display("[TB] FAIL midreset run: got done=%b cyc=%0d want done=0 cyc=6", obs_done, obs_cyc); else n_pass++;
    run_case(2, 1'b0, 10, d, d, 0, "rerun_after_reset");
  endtask

  task automatic test_random();
    int           s, sl, sw;
    logic [127:0] d_hit, d_chk;
    for (int it = 0; it < 24; it++) begin
      s     = $urandom_range(0, 2);
      d_hit = exp_data(s);
      d_chk = d_hit;
      if ($urandom_range(0, 1) == 1) begin
        sl = $urandom_range(0, nchk_p[s] - 1);
        d_hit[sl*32 +: 32] = d_hit[sl*32 +: 32] ^ ($urandom | 32'h1);
      end
      if ($urandom_range(0, 1) == 1) begin
        sl = $urandom_range(0, nchk_p[s] - 1);
        d_chk[sl*32 +: 32] = d_chk[sl*32 +: 32] ^ ($urandom | 32'h1);
      end
      sw = $urandom_range(0, settle_p[s] + nchk_p[s] + 1);
      run_case(s, 1'b0, $urandom_range(0, 40), d_hit, d_chk, sw, "random");
    end
  endtask

  initial begin
    $display("[TB] tb_end_checker bench start");
    test_reset("reset_initial");
    test_pass_sequence();
    test_mismatch();
    test_reset("reset_after_fail");
    test_x_slot();
    test_live_data();
    test_timeout();
    test_hit_vs_timeout();
    test_reset_mid_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
